// File: rtl/task_dispatcher.sv
// rtl/task_dispatcher.sv - descriptor FIFO feeding a valid/ready task issue channel with outstanding tracking
// Optional watchdog: define TASK_DISPATCH_TIMEOUT_EN to enable timeout_err.
module task_dispatcher #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        desc_wr_en,
  input  logic [31:0] desc_id,
  input  logic [31:0] desc_addr,
  input  logic [31:0] desc_size,
  output logic        desc_wr_ready,
  input  logic        dispatch_en,
  output logic [31:0] task_id,
  output logic [31:0] task_addr,
  output logic [31:0] task_size,
  output logic        task_valid,
  input  logic        task_ready,
  input  logic        task_complete,
  output logic [3:0]  outstanding,
  output logic [15:0] issued_cnt,
  output logic [15:0] completed_cnt,
  output logic        busy,
  output logic        underflow_err,
  output logic        timeout_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    MAX_OUT  = 4'(MAX_OUTSTANDING);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t        state_q, state_d;
  logic [95:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [95:0]   task_q, task_d;
  logic [3:0]    outstanding_q, outstanding_d;
  logic [15:0]   issued_q, issued_d, completed_q, completed_d;
  logic          underflow_q, underflow_d;
  logic          hs, comp_ok, can_load, load, push, full;

  // Handshake/completion accounting, FIFO control and issue FSM next state.
  always_comb begin
    state_d     = state_q;
    task_d      = task_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    hs          = (state_q == S_ISSUE) && task_ready;
    // A completion in the same cycle as a handshake is always legal.
    comp_ok     = task_complete && ((outstanding_q != 4'd0) || hs);
    outstanding_d = outstanding_q + {3'b000, hs} - {3'b000, comp_ok};
    issued_d    = issued_q + {15'd0, hs};
    completed_d = completed_q + {15'd0, comp_ok};
    underflow_d = underflow_q | (task_complete && (outstanding_q == 4'd0) && !hs);
    // The outstanding limit is judged on the value after this cycle's events.
    can_load    = (count_q != '0) && dispatch_en && (outstanding_d < MAX_OUT);
    load        = ((state_q == S_IDLE) || hs) && can_load;
    full        = (count_q == FULL_CNT);
    // A pop in this cycle frees the slot, so a full FIFO still accepts.
    desc_wr_ready = !full || load;
    push        = desc_wr_en && desc_wr_ready;
    count_d     = count_q + CW'(push) - CW'(load);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (load) begin
      task_d   = fifo_mem[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
      state_d  = S_ISSUE;
    end else if (hs) begin
      state_d  = S_IDLE;
    end
  end

  // Descriptor storage; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {desc_id, desc_addr, desc_size};
  end

  // State register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      task_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      issued_q      <= '0;
      completed_q   <= '0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      task_q        <= task_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      issued_q      <= issued_d;
      completed_q   <= completed_d;
      underflow_q   <= underflow_d;
    end
  end

`ifdef TASK_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_err_q, tmo_err_d;

  // Watchdog counts while work is outstanding; any completion restarts it.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((outstanding_q == 4'd0) || task_complete) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TMO_LIM) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    tmo_err_d = tmo_err_q | (tmo_cnt_d == TMO_LIM);
  end

  // Watchdog registers; the error stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign task_valid    = (state_q == S_ISSUE);
  assign task_id       = task_q[95:64];
  assign task_addr     = task_q[63:32];
  assign task_size     = task_q[31:0];
  assign outstanding   = outstanding_q;
  assign issued_cnt    = issued_q;
  assign completed_cnt = completed_q;
  assign underflow_err = underflow_q;
  assign busy          = (count_q != '0) || task_valid || (outstanding_q != 4'd0);

endmodule
